// File: rtl/cfg_master.sv
// Config write initiator: turns 4-byte UART command packets into one
// config write each and returns an ACK/NAK status byte.
module cfg_master #(
  parameter int          WIDTH_CONFIG_ADDR = 4,
  parameter int          WIDTH_CONFIG_DATA = 16,
  parameter int          TIMEOUT_CYCLES    = 1023,
  parameter logic [7:0]  SYNC_BYTE         = 8'hA5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data,
  output logic                         c_valid,
  input  logic                         c_ready,
  output logic [7:0]                   tx_data,
  output logic                         tx_valid,
  input  logic                         tx_ready,
  output logic                         busy
);

  localparam int WA = WIDTH_CONFIG_ADDR;
  localparam int WD = WIDTH_CONFIG_DATA;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_REQ,
    S_RESP
  } state_t;

  state_t        r_state, w_state;
  logic [WA-1:0] r_addr_sh, w_addr_sh;
  logic [7:0]    r_dhi, w_dhi;
  logic [WA-1:0] r_addr, w_addr;
  logic [WD-1:0] r_data, w_data;
  logic          r_cvalid, w_cvalid;
  logic          r_txvalid, w_txvalid;
  logic [7:0]    r_txdata, w_txdata;
  logic          r_busy, w_busy;
  logic [TW-1:0] r_timer, w_timer;
  logic [15:0]   w_word;

  assign w_word = {r_dhi, rx_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr_sh <= '0;
      r_dhi     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_cvalid  <= 1'b0;
      r_txvalid <= 1'b0;
      r_txdata  <= '0;
      r_busy    <= 1'b0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state;
      r_addr_sh <= w_addr_sh;
      r_dhi     <= w_dhi;
      r_addr    <= w_addr;
      r_data    <= w_data;
      r_cvalid  <= w_cvalid;
      r_txvalid <= w_txvalid;
      r_txdata  <= w_txdata;
      r_busy    <= w_busy;
      r_timer   <= w_timer;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_addr_sh = r_addr_sh;
    w_dhi     = r_dhi;
    w_addr    = r_addr;
    w_data    = r_data;
    w_cvalid  = r_cvalid;
    w_txvalid = r_txvalid;
    w_txdata  = r_txdata;
    w_timer   = r_timer;
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE)
          w_state = S_ADDR;
      end
      S_ADDR: begin
        if (rx_valid) begin
          w_addr_sh = rx_data[WA-1:0];
          w_state   = S_DHI;
        end
      end
      S_DHI: begin
        if (rx_valid) begin
          w_dhi   = rx_data;
          w_state = S_DLO;
        end
      end
      S_DLO: begin
        // Outputs only change here so they stay put between writes
        if (rx_valid) begin
          w_addr   = r_addr_sh;
          w_data   = w_word[WD-1:0];
          w_cvalid = 1'b1;
          w_timer  = '0;
          w_state  = S_REQ;
        end
      end
      S_REQ: begin
        if (c_ready) begin
          w_cvalid  = 1'b0;
          w_txdata  = ACK;
          w_txvalid = 1'b1;
          w_state   = S_RESP;
        end else if (r_timer == TLAST) begin
          w_cvalid  = 1'b0;
          w_txdata  = NAK;
          w_txvalid = 1'b1;
          w_state   = S_RESP;
        end else begin
          w_timer = r_timer + 1'b1;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          w_txvalid = 1'b0;
          w_state   = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_busy = (w_state == S_REQ) || (w_state == S_RESP);
  end

  assign c_addr   = r_addr;
  assign c_data   = r_data;
  assign c_valid  = r_cvalid;
  assign tx_data  = r_txdata;
  assign tx_valid = r_txvalid;
  assign busy     = r_busy;

endmodule

// File: doc/cfg_master.md
Name: cfg_master

Overview:
- Configuration initiator that drives the config write interface (c_addr/c_data/c_valid/c_ready) consumed by the clock divider and other configurable blocks.
- Receives 4-byte command packets from the UART receiver byte stream and issues exactly one config write per packet.
- Waits for the target's c_ready, with a timeout.
- Returns one status byte toward the UART transmitter.

Parameters:
- WIDTH_CONFIG_ADDR, 4, config address width (1..8).
- WIDTH_CONFIG_DATA, 16, config data width (1..16).
- TIMEOUT_CYCLES, 1023, max clk cycles c_valid is held without c_ready (>=1).
- SYNC_BYTE, 8'hA5, packet start marker.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
- c_addr  output  WIDTH_CONFIG_ADDR  config address.
- c_data  output  WIDTH_CONFIG_DATA  config data.
- c_valid  output  1  config write request.
- c_ready  input  1  target accepted/applied config.
- tx_data  output  8  status byte.
- tx_valid  output  1  status byte available.
- tx_ready  input  1  transmitter accepts status byte.
- busy  output  1  high in REQ and RESP states.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset (rst high at a clk edge): state IDLE; c_valid=0; c_addr=0; c_data=0; tx_valid=0; tx_data=0; busy=0; timer=0.
- Packet format: SYNC_BYTE, ADDR, DATA_HI, DATA_LO.
  - c_addr = ADDR[WIDTH_CONFIG_ADDR-1:0].
  - c_data = {DATA_HI,DATA_LO}[WIDTH_CONFIG_DATA-1:0]; upper bits are discarded.
- States: IDLE, ADDR, DHI, DLO, REQ, RESP.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> ADDR.
  - Any other byte is discarded; stay in IDLE.
- ADDR: rx_valid -> latch address, go to DHI.
- DHI: rx_valid -> latch high byte, go to DLO.
- DLO: rx_valid -> latch low byte into c_data; c_valid=1 from the next cycle; timer=0; go to REQ.
  - Latency: c_valid rises exactly 1 cycle after the DLO strobe cycle.
- No inter-byte timeout in ADDR/DHI/DLO. A SYNC_BYTE value arriving in ADDR/DHI/DLO is treated as payload, not a restart.
- REQ:
  - c_addr/c_data are held stable while c_valid=1.
  - Handshake completes at the first edge where c_valid && c_ready. Next cycle: c_valid=0, tx_data=8'h06 (ACK), tx_valid=1, state RESP.
  - Otherwise timer increments each cycle.
  - Timeout: at the edge where timer==TIMEOUT_CYCLES-1 and c_ready=0. Next cycle: c_valid=0, tx_data=8'h15 (NAK), tx_valid=1, state RESP.
  - So c_valid is high for exactly TIMEOUT_CYCLES cycles on timeout.
  - c_ready and timeout on the same edge: ACK wins.
  - c_ready already high when c_valid first rises: transfer completes on that first cycle; c_valid is high for 1 cycle.
- RESP:
  - tx_valid and tx_data are held until tx_valid && tx_ready at an edge.
  - Next cycle: tx_valid=0, state IDLE.
  - c_valid stays 0 for at least 1 cycle between transactions.
- rx bytes arriving in REQ or RESP are dropped; no buffering.
- c_ready while c_valid=0 is ignored.
- busy = (state==REQ) || (state==RESP).
- Reset mid-transaction (any state): all outputs return to reset values on the next edge. The partial packet is discarded; no status byte is sent.
- c_addr/c_data keep their last written values after a transaction; they are cleared only by reset.

Test Plan:
- Packet A5,03,00,32 with c_ready tied high -> c_valid high 1 cycle, starting 1 cycle after the last rx strobe, with c_addr=3, c_data=16'h0032; then tx_data=06, tx_valid=1; tx_ready=1 -> IDLE, busy=0.
- Packet A5,01,01,B2 with c_ready raised 5 cycles after c_valid -> c_valid high 6 cycles, c_data=16'h01B2 stable throughout; ACK 06.
- TIMEOUT_CYCLES=8, c_ready held 0 -> c_valid high exactly 8 cycles, then tx_data=15; c_ready asserted on the 8th cycle -> ACK 06 instead.
- Junk bytes 00,FF,12 then A5,02,AB,CD; extra byte 77 sent during REQ -> junk and 77 ignored, single write addr=2 data=ABCD; next packet processed normally.
- tx_ready held 0 for 10 cycles in RESP -> tx_valid/tx_data stable for 10 cycles; bytes arriving in that window are dropped; IDLE one cycle after tx_ready=1.
- rst pulsed in DHI, then in REQ -> all outputs 0 the next cycle, no status byte emitted; following full packet completes normally.
